// File: rtl/bp_fe_mem_responder.sv
// FE memory responder: ITLB, direct-mapped one-word I$, refill FSM.
// BP_FE_MEM_RESPONDER_PERF_EN adds saturating hit/miss perf counters.
module bp_fe_mem_responder #(
    parameter int vaddr_width_p       = 39,
    parameter int paddr_width_p       = 40,
    parameter int page_offset_width_p = 12,
    parameter int itlb_els_p          = 8,
    parameter int icache_sets_p       = 64,
    parameter logic [paddr_width_p-1:0] dram_base_p = 40'h80000000
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  mem_cmd_v_i,
    input  logic [1:0]            mem_cmd_op_i,
    input  logic [vaddr_width_p-1:0] mem_cmd_vaddr_i,
    input  logic [paddr_width_p-page_offset_width_p-1:0] mem_cmd_fill_ptag_i,
    input  logic                  mem_cmd_fill_x_i,
    input  logic                  mem_cmd_fill_u_i,
    output logic                  mem_cmd_yumi_o,
    input  logic [1:0]            mem_priv_i,
    input  logic                  mem_translation_en_i,
    input  logic                  mem_poison_i,
    output logic                  mem_resp_v_o,
    output logic [31:0]           mem_resp_data_o,
    output logic                  mem_resp_icache_miss_o,
    output logic                  mem_resp_itlb_miss_o,
    output logic                  mem_resp_page_fault_o,
    output logic                  mem_resp_access_fault_o,
    output logic                  bmem_req_v_o,
    output logic [paddr_width_p-1:0] bmem_req_paddr_o,
    input  logic                  bmem_req_ready_i,
    input  logic                  bmem_resp_v_i,
    input  logic [31:0]           bmem_resp_data_i
`ifdef BP_FE_MEM_RESPONDER_PERF_EN
   ,output logic [31:0]           perf_hit_cnt_o
   ,output logic [31:0]           perf_miss_cnt_o
`endif
);

    localparam int vtag_w  = vaddr_width_p - page_offset_width_p;
    localparam int ptag_w  = paddr_width_p - page_offset_width_p;
    localparam int tidx_w  = $clog2(itlb_els_p);
    localparam int cidx_w  = $clog2(icache_sets_p);
    localparam int ctag_w  = paddr_width_p - 2 - cidx_w;
    localparam int waddr_w = paddr_width_p - 2;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_req   = 2'd1,
        e_wait  = 2'd2
    } state_e;

    state_e state_r, state_n;

    logic is_fetch, is_fill, is_fence;
    logic fetch_acc, fill_acc, fence_acc;

    assign is_fetch = (mem_cmd_op_i == 2'd0);
    assign is_fill  = (mem_cmd_op_i == 2'd1);
    assign is_fence = (mem_cmd_op_i == 2'd2);

    // yumi is gated by reset so every output is 0 while reset is held
    assign mem_cmd_yumi_o = reset_n_i & mem_cmd_v_i
                          & (~is_fetch | (state_r == e_ready));

    assign fetch_acc = mem_cmd_yumi_o & is_fetch;
    assign fill_acc  = mem_cmd_yumi_o & is_fill;
    assign fence_acc = mem_cmd_yumi_o & is_fence;

    logic                     if2_v_r;
    logic [vaddr_width_p-1:0] if2_vaddr_r;
    logic [1:0]               if2_priv_r;
    logic                     if2_tr_en_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            if2_v_r     <= 1'b0;
            if2_vaddr_r <= '0;
            if2_priv_r  <= 2'd0;
            if2_tr_en_r <= 1'b0;
        end else begin
            if2_v_r <= fetch_acc;
            if (fetch_acc) begin
                if2_vaddr_r <= mem_cmd_vaddr_i;
                if2_priv_r  <= mem_priv_i;
                if2_tr_en_r <= mem_translation_en_i;
            end
        end
    end

    logic [itlb_els_p-1:0] tlb_v_r;
    logic [itlb_els_p-1:0] tlb_x_r;
    logic [itlb_els_p-1:0] tlb_u_r;
    logic [vtag_w-1:0]     tlb_vtag_r [itlb_els_p];
    logic [ptag_w-1:0]     tlb_ptag_r [itlb_els_p];
    logic [tidx_w-1:0]     rr_r;

    logic [vtag_w-1:0] if2_vtag, fill_vtag;
    logic              lk_hit, lk_x, lk_u;
    logic [ptag_w-1:0] lk_ptag;
    logic              fl_hit;
    logic [tidx_w-1:0] fl_idx, fl_way;

    assign if2_vtag  = if2_vaddr_r[vaddr_width_p-1:page_offset_width_p];
    assign fill_vtag = mem_cmd_vaddr_i[vaddr_width_p-1:page_offset_width_p];

    always_comb begin
        lk_hit  = 1'b0;
        lk_x    = 1'b0;
        lk_u    = 1'b0;
        lk_ptag = '0;
        for (int i = 0; i < itlb_els_p; i++) begin
            if (tlb_v_r[i] && (tlb_vtag_r[i] == if2_vtag)) begin
                lk_hit  = 1'b1;
                lk_x    = tlb_x_r[i];
                lk_u    = tlb_u_r[i];
                lk_ptag = tlb_ptag_r[i];
            end
        end
    end

    always_comb begin
        fl_hit = 1'b0;
        fl_idx = '0;
        for (int i = 0; i < itlb_els_p; i++) begin
            if (tlb_v_r[i] && (tlb_vtag_r[i] == fill_vtag)) begin
                fl_hit = 1'b1;
                fl_idx = tidx_w'(i);
            end
        end
    end

    assign fl_way = fl_hit ? fl_idx : rr_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tlb_v_r <= '0;
            rr_r    <= '0;
        end else if (fence_acc) begin
            tlb_v_r <= '0;
        end else if (fill_acc) begin
            tlb_v_r[fl_way] <= 1'b1;
            if (!fl_hit) rr_r <= rr_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_acc) begin
            tlb_vtag_r[fl_way] <= fill_vtag;
            tlb_ptag_r[fl_way] <= mem_cmd_fill_ptag_i;
            tlb_x_r[fl_way]    <= mem_cmd_fill_x_i;
            tlb_u_r[fl_way]    <= mem_cmd_fill_u_i;
        end
    end

    logic [paddr_width_p-1:0] paddr;
    logic                     va_hi_nz;

    assign paddr = if2_tr_en_r
                 ? {lk_ptag, if2_vaddr_r[page_offset_width_p-1:0]}
                 : paddr_width_p'(if2_vaddr_r);

    if (vaddr_width_p > paddr_width_p) begin : g_va_hi
        assign va_hi_nz = |if2_vaddr_r[vaddr_width_p-1:paddr_width_p];
    end else begin : g_va_no_hi
        assign va_hi_nz = 1'b0;
    end

    logic [icache_sets_p-1:0] c_v_r;
    logic [ctag_w-1:0]        c_tag_r  [icache_sets_p];
    logic [31:0]              c_data_r [icache_sets_p];

    logic [cidx_w-1:0] c_idx;
    logic [ctag_w-1:0] c_tag;
    logic              c_hit;

    assign c_idx = paddr[2 +: cidx_w];
    assign c_tag = paddr[paddr_width_p-1 -: ctag_w];
    assign c_hit = c_v_r[c_idx] & (c_tag_r[c_idx] == c_tag);

    logic unused_ok;
    assign unused_ok = ^paddr[1:0];

    logic resp_v, tlb_miss, pg_fault, acc_fault;
    logic resp_cmiss, resp_hit;

    assign resp_v    = if2_v_r & ~mem_poison_i;
    assign tlb_miss  = if2_tr_en_r & ~lk_hit;
    assign pg_fault  = if2_tr_en_r & lk_hit
                     & (~lk_x
                     | ((if2_priv_r == 2'd0) & ~lk_u)
                     | ((if2_priv_r == 2'd1) & lk_u));
    assign acc_fault = ~tlb_miss & ~pg_fault
                     & ((paddr < dram_base_p)
                     | (~if2_tr_en_r & va_hi_nz));
    assign resp_cmiss = ~tlb_miss & ~pg_fault & ~acc_fault & ~c_hit;
    assign resp_hit   = ~tlb_miss & ~pg_fault & ~acc_fault & c_hit;

    assign mem_resp_v_o            = resp_v;
    assign mem_resp_itlb_miss_o    = resp_v & tlb_miss;
    assign mem_resp_page_fault_o   = resp_v & pg_fault;
    assign mem_resp_access_fault_o = resp_v & acc_fault;
    assign mem_resp_icache_miss_o  = resp_v & resp_cmiss;
    assign mem_resp_data_o = (resp_v & resp_hit) ? c_data_r[c_idx] : 32'd0;

    logic [waddr_w-1:0] miss_addr_r;
    logic               miss_cap, refill_we;
    logic [cidx_w-1:0]  m_idx;
    logic [ctag_w-1:0]  m_tag;

    assign m_idx = miss_addr_r[cidx_w-1:0];
    assign m_tag = miss_addr_r[waddr_w-1:cidx_w];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= e_ready;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_ready: if (resp_v & resp_cmiss) state_n = e_req;
            e_req:   if (bmem_req_ready_i)    state_n = e_wait;
            e_wait:  if (bmem_resp_v_i)       state_n = e_ready;
            default: state_n = e_ready;
        endcase
    end

    always_comb begin
        bmem_req_v_o = 1'b0;
        miss_cap     = 1'b0;
        refill_we    = 1'b0;
        unique case (state_r)
            e_ready: miss_cap     = resp_v & resp_cmiss;
            e_req:   bmem_req_v_o = 1'b1;
            e_wait:  refill_we    = bmem_resp_v_i;
            default: ;
        endcase
    end

    assign bmem_req_paddr_o = bmem_req_v_o ? {miss_addr_r, 2'b00} : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            miss_addr_r <= '0;
            c_v_r       <= '0;
        end else begin
            if (miss_cap)  miss_addr_r  <= paddr[paddr_width_p-1:2];
            if (refill_we) c_v_r[m_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (refill_we) begin
            c_tag_r[m_idx]  <= m_tag;
            c_data_r[m_idx] <= bmem_resp_data_i;
        end
    end

`ifdef BP_FE_MEM_RESPONDER_PERF_EN
    logic [31:0] hit_cnt_r, miss_cnt_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
        end else begin
            if (resp_v & resp_hit & (hit_cnt_r != '1))
                hit_cnt_r <= hit_cnt_r + 32'd1;
            if (resp_v & resp_cmiss & (miss_cnt_r != '1))
                miss_cnt_r <= miss_cnt_r + 32'd1;
        end
    end

    assign perf_hit_cnt_o  = hit_cnt_r;
    assign perf_miss_cnt_o = miss_cnt_r;
`else
`endif

endmodule

// File: tb/tb_bp_fe_mem_responder.sv
// Bench for bp_fe_mem_responder: directed plan cases plus random traffic
// checked cycle by cycle against a behavioural model of the responder.
module tb_bp_fe_mem_responder;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b1;
    logic        mem_cmd_v_i = 1'b0;
    logic [1:0]  mem_cmd_op_i = 2'd0;
    logic [38:0] mem_cmd_vaddr_i = '0;
    logic [27:0] mem_cmd_fill_ptag_i = '0;
    logic        mem_cmd_fill_x_i = 1'b0;
    logic        mem_cmd_fill_u_i = 1'b0;
    logic        mem_cmd_yumi_o;
    logic [1:0]  mem_priv_i = 2'd3;
    logic        mem_translation_en_i = 1'b0;
    logic        mem_poison_i = 1'b0;
    logic        mem_resp_v_o;
    logic [31:0] mem_resp_data_o;
    logic        mem_resp_icache_miss_o;
    logic        mem_resp_itlb_miss_o;
    logic        mem_resp_page_fault_o;
    logic        mem_resp_access_fault_o;
    logic        bmem_req_v_o;
    logic [39:0] bmem_req_paddr_o;
    logic        bmem_req_ready_i = 1'b0;
    logic        bmem_resp_v_i = 1'b0;
    logic [31:0] bmem_resp_data_i = '0;
`ifdef BP_FE_MEM_RESPONDER_PERF_EN
    logic [31:0] perf_hit_cnt_o, perf_miss_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    bp_fe_mem_responder dut (
        .clk_i                   (clk_i),
        .reset_n_i               (reset_n_i),
        .mem_cmd_v_i             (mem_cmd_v_i),
        .mem_cmd_op_i            (mem_cmd_op_i),
        .mem_cmd_vaddr_i         (mem_cmd_vaddr_i),
        .mem_cmd_fill_ptag_i     (mem_cmd_fill_ptag_i),
        .mem_cmd_fill_x_i        (mem_cmd_fill_x_i),
        .mem_cmd_fill_u_i        (mem_cmd_fill_u_i),
        .mem_cmd_yumi_o          (mem_cmd_yumi_o),
        .mem_priv_i              (mem_priv_i),
        .mem_translation_en_i    (mem_translation_en_i),
        .mem_poison_i            (mem_poison_i),
        .mem_resp_v_o            (mem_resp_v_o),
        .mem_resp_data_o         (mem_resp_data_o),
        .mem_resp_icache_miss_o  (mem_resp_icache_miss_o),
        .mem_resp_itlb_miss_o    (mem_resp_itlb_miss_o),
        .mem_resp_page_fault_o   (mem_resp_page_fault_o),
        .mem_resp_access_fault_o (mem_resp_access_fault_o),
        .bmem_req_v_o            (bmem_req_v_o),
        .bmem_req_paddr_o        (bmem_req_paddr_o),
        .bmem_req_ready_i        (bmem_req_ready_i),
        .bmem_resp_v_i           (bmem_resp_v_i),
        .bmem_resp_data_i        (bmem_resp_data_i)
`ifdef BP_FE_MEM_RESPONDER_PERF_EN
       ,.perf_hit_cnt_o          (perf_hit_cnt_o)
       ,.perf_miss_cnt_o         (perf_miss_cnt_o)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // model: pending fetch, translation table, resident lines, refill
    bit          q_v;
    logic [38:0] q_va;
    logic [1:0]  q_priv;
    bit          q_tr;
    bit          t_v[8];
    logic [26:0] t_vtag[8];
    logic [27:0] t_ptag[8];
    bit          t_x[8], t_u[8];
    int          rr;
    bit          c_v[64];
    logic [37:0] c_wa[64];
    bit          pend, issued;
    int          dly;
    logic [39:0] req_pa;
    bit          rnd_mem = 1'b0;
    int          fix_dly = 0;

    function automatic logic [31:0] mem_fn(input logic [39:0] pa);
        if (pa == 40'h80000000) return 32'h00000013;
        return pa[31:0] ^ 32'hA5A50000 ^ {24'h0, pa[39:32]};
    endfunction

    task automatic model_reset();
        q_v = 0; rr = 0; pend = 0; issued = 0; dly = 0;
        for (int i = 0; i < 8; i++) t_v[i] = 0;
        for (int i = 0; i < 64; i++) c_v[i] = 0;
    endtask

    task automatic step(input bit v, input logic [1:0] op,
                        input logic [38:0] va, input logic [27:0] ptag,
                        input bit x, input bit u, input logic [1:0] priv,
                        input bit tr, input bit poison);
        bit ey, rv, tm, pf, af, cm, hit, found, deliver, cap, fh;
        bit mx, mu;
        logic [27:0] mp;
        logic [39:0] pa;
        logic [31:0] ed;
        int fi;
        @(negedge clk_i);
        mem_cmd_v_i = v; mem_cmd_op_i = op; mem_cmd_vaddr_i = va;
        mem_cmd_fill_ptag_i = ptag; mem_cmd_fill_x_i = x;
        mem_cmd_fill_u_i = u; mem_priv_i = priv;
        mem_translation_en_i = tr; mem_poison_i = poison;
        bmem_req_ready_i = rnd_mem ? 1'($urandom % 2) : 1'b1;
        deliver = issued && (dly == 0);
        bmem_resp_data_i = $urandom;
        bmem_resp_v_i = 1'b0;
        if (deliver) begin
            bmem_resp_v_i = 1'b1;
            bmem_resp_data_i = mem_fn(req_pa);
        end else if (rnd_mem && !issued && ($urandom % 6 == 0)) begin
            bmem_resp_v_i = 1'b1;
        end
        ey = v && (op != 2'd0 || !pend);
        rv = q_v && !poison;
        tm = 0; pf = 0; af = 0; cm = 0; hit = 0; ed = 0; pa = 0;
        found = 0; mp = 0; mx = 0; mu = 0;
        if (rv) begin
            for (int i = 0; i < 8; i++)
                if (t_v[i] && t_vtag[i] == q_va[38:12]) begin
                    found = 1; mp = t_ptag[i]; mx = t_x[i]; mu = t_u[i];
                end
            pa = q_tr ? {mp, q_va[11:0]} : {1'b0, q_va};
            if (q_tr && !found) tm = 1;
            else if (q_tr && (!mx || (q_priv == 0 && !mu)
                     || (q_priv == 1 && mu))) pf = 1;
            else if (pa < 40'h80000000) af = 1;
            else if (c_v[pa[7:2]] && c_wa[pa[7:2]] == pa[39:2]) begin
                hit = 1; ed = mem_fn({pa[39:2], 2'b00});
            end else cm = 1;
        end
        #1;
        chk("yumi", mem_cmd_yumi_o, ey);
        chk("resp_v", mem_resp_v_o, rv);
        chk("resp_data", mem_resp_data_o, ed);
        chk("itlb_miss", mem_resp_itlb_miss_o, tm);
        chk("page_fault", mem_resp_page_fault_o, pf);
        chk("access_fault", mem_resp_access_fault_o, af);
        chk("icache_miss", mem_resp_icache_miss_o, cm);
        chk("bmem_req_v", bmem_req_v_o, pend && !issued);
        chk("bmem_req_pa", bmem_req_paddr_o,
            (pend && !issued) ? req_pa : 40'h0);
        cap = cm && !pend;
        if (deliver) begin
            c_v[req_pa[7:2]] = 1; c_wa[req_pa[7:2]] = req_pa[39:2];
            pend = 0; issued = 0;
        end else if (pend && !issued && bmem_req_ready_i) begin
            issued = 1; dly = rnd_mem ? int'($urandom % 3) : fix_dly;
        end else if (issued && dly > 0) dly--;
        if (cap) begin
            pend = 1; issued = 0; req_pa = {pa[39:2], 2'b00};
        end
        if (v && op == 2'd1) begin
            fh = 0; fi = rr;
            for (int i = 0; i < 8; i++)
                if (t_v[i] && t_vtag[i] == va[38:12]) begin
                    fh = 1; fi = i;
                end
            t_v[fi] = 1; t_vtag[fi] = va[38:12]; t_ptag[fi] = ptag;
            t_x[fi] = x; t_u[fi] = u;
            if (!fh) rr = (rr + 1) % 8;
        end else if (v && op == 2'd2) begin
            for (int i = 0; i < 8; i++) t_v[i] = 0;
        end
        q_v = v && op == 2'd0 && ey;
        if (q_v) begin q_va = va; q_priv = priv; q_tr = tr; end
    endtask

    task automatic idle(input bit poison = 0);
        step(0, 2'd0, '0, '0, 0, 0, 2'd3, 0, poison);
    endtask

    task automatic fetch(input logic [38:0] va, input logic [1:0] priv,
                         input bit tr);
        step(1, 2'd0, va, '0, 0, 0, priv, tr, 0);
    endtask

    task automatic fill(input logic [26:0] vt, input logic [27:0] pt,
                        input bit x, input bit u);
        step(1, 2'd1, {vt, 12'h000}, pt, x, u, 2'd3, 0, 0);
    endtask

    task automatic fence();
        step(1, 2'd2, '0, '0, 0, 0, 2'd3, 0, 0);
    endtask

    task automatic wait_refill();
        for (int i = 0; i < 30 && pend; i++) idle();
        chk("refill_timeout", pend, 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk_i);
        mem_cmd_v_i = 1; mem_cmd_op_i = 2'd1;
        bmem_resp_v_i = 0; mem_poison_i = 0;
        #2 reset_n_i = 1'b0;
        #1;
        chk("rst_yumi", mem_cmd_yumi_o, 0);
        chk("rst_resp_v", mem_resp_v_o, 0);
        chk("rst_data", mem_resp_data_o, 0);
        chk("rst_flags", {mem_resp_icache_miss_o, mem_resp_itlb_miss_o,
            mem_resp_page_fault_o, mem_resp_access_fault_o}, 0);
        chk("rst_req_v", bmem_req_v_o, 0);
        chk("rst_req_pa", bmem_req_paddr_o, 0);
        model_reset();
        mem_cmd_v_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        logic [1:0] privs [3];
        privs = '{2'd0, 2'd1, 2'd3};
        model_reset();
        reset_pulse();
        // case 1
        fetch(39'h80000000, 2'd3, 0); idle();
        wait_refill();
        fetch(39'h80000000, 2'd3, 0); idle();
        // case 2
        fetch(39'h4000, 2'd1, 1); idle();
        fill(27'h4, 28'h80000, 1, 0);
        fetch(39'h4000, 2'd1, 1);
        fetch(39'h4004, 2'd1, 1); idle();
        wait_refill();
        fetch(39'h4004, 2'd1, 1); idle();
        // case 3
        fetch(39'h4000, 2'd0, 1); idle();
        fill(27'h4, 28'h80000, 0, 0);
        fetch(39'h4000, 2'd1, 1); idle();
        fetch(39'h1000, 2'd3, 0); idle();
        // case 4
        fetch(39'h80000100, 2'd3, 0); idle(1); idle(); idle();
        // case 5
        fence();
        for (int i = 0; i < 9; i++) fill(27'h10 + 27'(i), 28'h80000, 1, 0);
        for (int i = 0; i < 9; i++) fetch({27'h10 + 27'(i), 12'h0}, 2'd1, 1);
        idle();
        fence();
        for (int i = 1; i < 4; i++) fetch({27'h10 + 27'(i), 12'h0}, 2'd1, 1);
        idle();
        fetch({27'h20, 12'h0}, 2'd1, 1);
        fill(27'h20, 28'h80000, 1, 0);
        fetch({27'h20, 12'h0}, 2'd1, 1); idle();
        // case 6
        fix_dly = 3;
        fetch(39'h80000040, 2'd3, 0); idle(); idle();
        reset_pulse();
        fix_dly = 0;
        fetch(39'h80000000, 2'd3, 0); idle();
        wait_refill();
        // random traffic
        rnd_mem = 1;
        for (int n = 0; n < 3000; n++) begin
            int r, s;
            logic [38:0] va;
            logic [27:0] pt;
            r = int'($urandom % 100);
            s = int'($urandom % 10);
            if (s < 7)
                va = 39'h80000000 + 39'($urandom % 16 * 4)
                   + (($urandom % 2 == 1) ? 39'h100 : 39'h0);
            else if (s < 9) va = 39'($urandom % 32'h80000000);
            else va = {1'b1, 38'($urandom)};
            case ($urandom % 4)
                0, 1: pt = 28'h80000;
                2: pt = 28'h80001;
                default: pt = 28'h00007;
            endcase
            if (r < 30)
                step(1, 2'd0, va, pt, 0, 0, privs[$urandom % 3], 0,
                     ($urandom % 10) == 0);
            else if (r < 60)
                step(1, 2'd0, {27'(4 + $urandom % 12),
                     12'($urandom % 16 * 4 + $urandom % 4)}, pt, 0, 0,
                     privs[$urandom % 3], 1, ($urandom % 10) == 0);
            else if (r < 75)
                step(1, 2'd1, {27'(4 + $urandom % 12), 12'($urandom)}, pt,
                     ($urandom % 4) != 0, 1'($urandom % 2),
                     privs[$urandom % 3], 1'($urandom % 2),
                     ($urandom % 10) == 0);
            else if (r < 78)
                step(1, 2'd2, va, pt, 0, 0, 2'd3, 0, ($urandom % 10) == 0);
            else if (r < 80)
                step(1, 2'd3, va, pt, 1, 1, 2'd3, 1, ($urandom % 10) == 0);
            else
                step(0, 2'($urandom), va, pt, 0, 0, 2'd3,
                     1'($urandom % 2), ($urandom % 10) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bp_fe_mem_responder.md
Name: bp_fe_mem_responder

Overview:
Responder end of the FE memory command/response interface. It accepts fetch, ITLB-fill and ITLB-fence commands from the FE PC generator and returns one response per accepted fetch, exactly one cycle later (IF2). It contains a small fully-associative ITLB and a direct-mapped one-word-per-line instruction cache. Cache misses are serviced from a backing memory port by a refill state machine.

Parameters:
vaddr_width_p, 39, virtual address width
paddr_width_p, 40, physical address width
page_offset_width_p, 12, page offset bits; vtag = vaddr[vaddr_width_p-1:12], ptag = paddr[paddr_width_p-1:12]
itlb_els_p, 8, ITLB entries (power of 2)
icache_sets_p, 64, cache lines, one 32-bit instruction each (power of 2)
dram_base_p, 40'h80000000, physical addresses below this raise an access fault

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
mem_cmd_v_i  in  1  command valid
mem_cmd_op_i  in  2  0=fetch, 1=tlb_fill, 2=tlb_fence, 3=reserved (accepted, ignored)
mem_cmd_vaddr_i  in  vaddr_width_p  fetch address / fill vtag source
mem_cmd_fill_ptag_i  in  paddr_width_p-12  fill ptag
mem_cmd_fill_x_i  in  1  fill: executable
mem_cmd_fill_u_i  in  1  fill: user page
mem_cmd_yumi_o  out  1  command accepted this cycle
mem_priv_i  in  2  privilege for the fetch (0=U, 1=S, 3=M)
mem_translation_en_i  in  1  translation enable for the fetch
mem_poison_i  in  1  kill the fetch currently in IF2
mem_resp_v_o  out  1  response valid
mem_resp_data_o  out  32  instruction
mem_resp_icache_miss_o  out  1  fetch missed; refill started
mem_resp_itlb_miss_o  out  1  no translation
mem_resp_page_fault_o  out  1  permission failure
mem_resp_access_fault_o  out  1  illegal physical address
bmem_req_v_o  out  1  refill request valid
bmem_req_paddr_o  out  paddr_width_p  word-aligned refill address
bmem_req_ready_i  in  1  backing memory accepts the request
bmem_resp_v_i  in  1  refill data valid
bmem_resp_data_i  in  32  refill data

Behaviour:
- Reset (asynchronous, active-low):
  - All ITLB and cache valid bits, the IF2 valid flag, the round-robin pointer and the FSM are cleared; FSM enters e_ready.
  - All outputs are 0.
- Acceptance:
  - mem_cmd_yumi_o = mem_cmd_v_i for op != fetch, in any state.
  - For fetch, mem_cmd_yumi_o = mem_cmd_v_i & (state == e_ready).
- IF1 capture: an accepted fetch registers vaddr, priv and translation_en, and sets the IF2 valid flag for the next cycle.
- IF2 (the cycle after acceptance):
  - ITLB CAM lookup, fault check and cache read use the registered values.
  - mem_resp_v_o = IF2 valid & ~mem_poison_i.
  - Poison suppresses the response and any miss handling.
- Translation:
  - When translation is off, paddr = vaddr[paddr_width_p-1:0]; there is no TLB or page check.
  - When translation is on, paddr = {matching ptag, page offset}.
- Exception priority (exactly one flag set; data = 0 when a flag is set):
  1. itlb_miss: translation on and no vtag match.
  2. page_fault: ~x, or (priv==U & ~u), or (priv==S & u).
  3. access_fault: paddr < dram_base_p, or translation off with nonzero vaddr bits above paddr_width_p.
  4. icache_miss: cache valid/tag mismatch.
  Otherwise the response is a hit and returns the line data.
- Cache addressing: index = paddr[2 +: log2(icache_sets_p)]; tag = remaining upper paddr bits. paddr[1:0] is ignored.
- FSM:
  - e_ready: an unpoisoned icache_miss captures paddr and moves to e_req.
  - e_req: bmem_req_v_o = 1 with the captured word address; move to e_wait when bmem_req_ready_i.
  - e_wait: on bmem_resp_v_i, write data, tag and valid; move to e_ready.
  - No response is produced for the missing fetch after the refill. The initiator re-fetches.
- ITLB fill:
  - If the vtag is already present, that entry is overwritten.
  - Otherwise the entry at the round-robin pointer is written and the pointer increments, wrapping at itlb_els_p.
  - The write takes effect at the clock edge. A same-cycle IF2 lookup sees the old contents.
- ITLB fence: invalidates all entries in one cycle. It does not touch the cache. It may coincide with a refill.
- Fill and fence arriving while in e_req/e_wait are accepted and applied immediately.

Optional Feature:
BP_FE_MEM_RESPONDER_PERF_EN
- Defined:
  - Adds outputs perf_hit_cnt_o [31:0] and perf_miss_cnt_o [31:0].
  - These are saturating counters of unpoisoned hit and icache_miss responses.
  - Cleared by reset.
- Undefined: the ports and counters do not exist. Functional behaviour is identical either way.

Test Plan:
1. Translation off; fetch 0x80000000 twice, with backing memory returning 0x00000013 one cycle after the request is accepted.
   -> First response: icache_miss=1. Refill request paddr 0x80000000. After refill, the retry hits with data 0x00000013, exactly one cycle after yumi.
2. Translation on; fetch vaddr 0x4000 with empty ITLB -> itlb_miss=1. Fill vtag 0x4 to ptag 0x80000 with x=1, u=0; refetch at priv S -> paddr 0x80000000, with the hit/miss path as in case 1.
3. With the same entry, fetch at priv U -> page_fault=1. Fill with x=0, priv S -> page_fault=1. Translation off, fetch 0x1000 -> access_fault=1.
4. Assert mem_poison_i in the IF2 cycle of a missing fetch -> mem_resp_v_o=0, no bmem_req_v_o, FSM stays e_ready.
5. Fill 9 distinct vtags into 8 entries -> the first vtag misses and the others hit. Fence -> all miss. A fill concurrent with an IF2 lookup of the same vtag -> that lookup misses and the next one hits.
6. Deassert reset_n_i during e_wait -> outputs 0 immediately and bmem_req_v_o low. After release, a previously filled address misses again.
